// File: rtl/oam_dma.sv
// oam_dma: sprite DMA that halts the CPU on a trigger write and copies one page to OAMDATA
// clk, reset                    : system clock, synchronous active-high reset
// cpu_addr, cpu_write, cpu_d_out: snooped CPU bus (trigger detection and source page)
// bus_d_in                      : memory read data for DMA reads
// cpu_ready                     : CPU ready, low while the DMA owns the bus
// dma_active                    : bus mux select toward the dma_* signals
// dma_addr, dma_write, dma_d_out: DMA bus master outputs
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          COUNT        = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_ready,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_write,
  output logic [7:0]  dma_d_out
);
  localparam logic [7:0] LAST = 8'(COUNT - 1);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t     state_q;
  logic [7:0] page_q, idx_q, latch_q;
  logic       parity_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      latch_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      case (state_q)
        IDLE:
          if (cpu_write && cpu_addr == TRIGGER_ADDR) begin
            page_q  <= cpu_d_out;
            idx_q   <= '0;
            state_q <= HALT;
          end
        // a HALT on an odd cycle lands the first READ on an even (get) cycle directly
        HALT:  state_q <= parity_q ? READ : ALIGN;
        ALIGN: state_q <= READ;
        READ: begin
          latch_q <= bus_d_in;
          state_q <= WRITE;
        end
        WRITE:
          if (idx_q == LAST) state_q <= IDLE;
          else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= READ;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cpu_ready  = state_q == IDLE;
  assign dma_active = ~cpu_ready;
  assign dma_write  = state_q == WRITE;
  assign dma_addr   = state_q == READ ? {page_q, idx_q} : dma_write ? DEST_ADDR : 16'h0000;
  assign dma_d_out  = dma_write ? latch_q : 8'h00;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma against a transaction-level model
module tb_oam_dma;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic [7:0]  bus_d_in;
  logic        cpu_ready, dma_active, dma_write;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;
  logic [7:0]  mem [65536];
  logic        pc;
  int          checks = 0;
  int          failures = 0;

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_d_out(cpu_d_out), .bus_d_in(bus_d_in), .cpu_ready(cpu_ready),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_write(dma_write),
    .dma_d_out(dma_d_out)
  );

  always #5 clk = ~clk;
  always_comb bus_d_in = mem[dma_addr];
  // parity of the current cycle as seen by the reference timeline
  always @(posedge clk) pc <= reset ? 1'b0 : ~pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {12'h0, cpu_ready, dma_active, dma_write, dma_addr, dma_d_out}, {12'h0, 3'b100, 16'h0, 8'h0});
  endtask

  // one full transfer; align selects whether the HALT cycle lands on parity 0
  task automatic run_xfer(input logic [7:0] page, input bit align, input int inj);
    int k = 0;
    int h = align ? 2 : 1;
    logic [24:0] exp_bus;
    while (pc != align) step();
    cpu_write = 1'b1; cpu_addr = TRIG; cpu_d_out = page;
    @(negedge clk);
    check_idle("trigger_cycle");
    step();
    while (k < 600) begin
      if (inj > 0 && k == inj) begin
        cpu_write = 1'b1; cpu_addr = TRIG; cpu_d_out = 8'h12;
      end else begin
        cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
      end
      @(negedge clk);
      if (!dma_active) break;
      chk("busy_ready_low", {31'h0, cpu_ready}, 32'h0);
      if (k < h + 512) begin
        int j = k - h;
        logic [15:0] src = {page, 8'(j / 2)};
        if (k < h) exp_bus = {16'h0000, 1'b0, 8'h00};
        else if (j % 2 == 0) exp_bus = {src, 1'b0, 8'h00};
        else exp_bus = {DEST, 1'b1, mem[src]};
        chk($sformatf("bus_k%0d", k), {7'h0, dma_addr, dma_write, dma_d_out}, {7'h0, exp_bus});
        if (k >= h && j % 2 == 0) chk("read_parity", {31'h0, pc}, 32'h0);
      end
      k++;
      step();
    end
    chk("busy_len", k, align ? 514 : 513);
    check_idle("after_xfer");
    step();
    cpu_write = 1'b0; cpu_addr = 16'h0000;
  endtask

  initial begin
    logic [15:0] wa [6] = '{16'h2004, 16'h4015, 16'h4013, 16'h4014, 16'h0014, 16'hC014};
    logic        ww [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  wd [6] = '{8'hAA, 8'h3F, 8'h55, 8'h02, 8'h03, 8'h04};
    int k;
    reset = 1'b1; cpu_addr = '0; cpu_write = 1'b0; cpu_d_out = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
    step();
    @(negedge clk);
    check_idle("reset_state");
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_write = ww[i]; cpu_addr = wa[i]; cpu_d_out = wd[i];
      @(negedge clk);
      check_idle($sformatf("non_trigger_%0d", i));
      step();
      cpu_write = 1'b0; cpu_addr = '0;
      @(negedge clk);
      check_idle($sformatf("non_trigger_after_%0d", i));
      step();
    end
    run_xfer(8'h02, 1'b0, 0);
    run_xfer(8'($urandom_range(1, 254)), 1'b1, 0);
    run_xfer(8'h03, 1'($urandom), 0);
    while (pc != 1'b0) step();
    cpu_write = 1'b1; cpu_addr = TRIG; cpu_d_out = 8'h05;
    step();
    cpu_write = 1'b0; cpu_addr = '0;
    k = 1;
    while (k < 100) begin
      step();
      k++;
    end
    @(negedge clk);
    chk("abort_still_busy", {31'h0, dma_active}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_idle("abort_next_cycle");
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check_idle("abort_quiet");
    end
    step();
    run_xfer(8'h04, 1'($urandom), 0);
    reset = 1'b1; cpu_write = 1'b1; cpu_addr = TRIG; cpu_d_out = 8'h07;
    step();
    reset = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
    @(negedge clk);
    check_idle("reset_beats_trigger");
    step();
    @(negedge clk);
    check_idle("reset_beats_trigger_2");
    step();
    run_xfer(8'hFF, 1'($urandom), int'($urandom_range(5, 400)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("no_retrigger");
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
